// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding valid/ready load/store target with
// size-aware extension and RMW sub-dword stores. Option: DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        MERGE = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size)
            2'b00:   align_mask = 3'b111;
            2'b01:   align_mask = 3'b011;
            2'b10:   align_mask = 3'b001;
            default: align_mask = 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] byte_mask(input logic [1:0] size);
        case (size)
            2'b00:   byte_mask = 8'hFF;
            2'b01:   byte_mask = 8'h0F;
            2'b10:   byte_mask = 8'h03;
            default: byte_mask = 8'h01;
        endcase
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] dword, input logic [2:0] lane,
                                                input logic [1:0] size, input logic sgn);
        logic [63:0] sh;
        sh = dword >> {lane, 3'b000};
        case (size)
            2'b00:   load_extend = sh;
            2'b01:   load_extend = {{32{sgn & sh[31]}}, sh[31:0]};
            2'b10:   load_extend = {{48{sgn & sh[15]}}, sh[15:0]};
            default: load_extend = {{56{sgn & sh[7]}}, sh[7:0]};
        endcase
    endfunction

    logic [63:0]   mem_r [DEPTH];
    state_t        state_r, state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [AW-1:0] idx_r, idx_s, mem_idx_s;
    logic [2:0]    lane_r, lane_s;
    logic [1:0]    size_r;
    logic          signed_r;
    logic [63:0]   wdata_r, merge_r, merged_s, wsh_s, mem_wdata_s, rdata_nxt_s;
    logic [7:0]    bmask_s;
    logic          accept_s, oor_s, mis_s, err_s, mem_we_s, err_nxt_s;

    assign accept_s = req_valid && req_ready;
    assign idx_s    = req_addr[AW+2:3];
    assign oor_s    = |req_addr[63:AW+3];
    assign err_s    = oor_s || mis_s;

    // Lane selection: trap on misalignment, or force alignment by clearing low bits
    always_comb begin
        lane_s = req_addr[2:0];
        mis_s  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis_s  = |(req_addr[2:0] & align_mask(req_size));
`else
        lane_s = req_addr[2:0] & ~align_mask(req_size);
`endif
    end

    // Byte-merge of captured store data into the buffered doubleword
    always_comb begin
        wsh_s   = wdata_r << {lane_r, 3'b000};
        bmask_s = byte_mask(size_r) << lane_r;
        for (int b = 0; b < 8; b++) begin
            merged_s[8*b +: 8] = bmask_s[b] ? wsh_s[8*b +: 8] : merge_r[8*b +: 8];
        end
    end

    // Next-state, array write strobe and response payload
    always_comb begin
        state_nxt_s = state_r;
        mem_we_s    = 1'b0;
        mem_idx_s   = idx_r;
        mem_wdata_s = merged_s;
        rdata_nxt_s = 64'd0;
        err_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (err_s) begin
                        state_nxt_s = RESP;
                        err_nxt_s   = 1'b1;
                    end else if (!req_we) begin
                        state_nxt_s = WAIT;
                    end else if (req_size == 2'b00) begin
                        mem_we_s    = 1'b1;
                        mem_idx_s   = idx_s;
                        mem_wdata_s = req_wdata;
                        state_nxt_s = RESP;
                    end else begin
                        state_nxt_s = MERGE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == CW'(0)) begin
                    state_nxt_s = RESP;
                    rdata_nxt_s = load_extend(mem_r[idx_r], lane_r, size_r, signed_r);
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            MERGE: begin
                mem_we_s    = 1'b1;
                state_nxt_s = RESP;
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM, wait counter, request capture and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= CW'(0);
            idx_r     <= '0;
            lane_r    <= 3'd0;
            size_r    <= 2'd0;
            signed_r  <= 1'b0;
            wdata_r   <= 64'd0;
            merge_r   <= 64'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 64'd0;
            rsp_err   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            req_ready <= (state_nxt_s == IDLE);
            rsp_valid <= (state_nxt_s == RESP);
            rsp_rdata <= rdata_nxt_s;
            rsp_err   <= err_nxt_s;
            if (accept_s) begin
                cnt_r    <= CW'(READ_LAT - 1);
                idx_r    <= idx_s;
                lane_r   <= lane_s;
                size_r   <= req_size;
                signed_r <= req_signed;
                wdata_r  <= req_wdata;
                merge_r  <= mem_r[idx_s];
            end else if (state_r == WAIT && cnt_r != CW'(0)) begin
                cnt_r <= cnt_r - CW'(1);
            end
        end
    end

    // Storage array; deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_idx_s] <= mem_wdata_s;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed table-driven bench for dmem_responder plus hand sequences for
// back-to-back requests and reset during a read-modify-write.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [63:0] rsp_rdata;

    int n_chk = 0;
    int n_err = 0;

    dmem_responder #(.DEPTH(256), .READ_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkint(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        req_we     = v.we;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_valid  = 1'b1;
        chk64({tag, " ready_idle"}, {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk64({tag, " ready_busy"}, {63'd0, req_ready}, 64'd0);
        lat = 1;
        while (!rsp_valid && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        chkint({tag, " latency"}, lat, v.exp_lat);
        chk64({tag, " rdata"}, rsp_rdata, v.exp_rdata);
        chk64({tag, " err"}, {63'd0, rsp_err}, {63'd0, v.exp_err});
        @(posedge clk); #1;
        chk64({tag, " pulse_end"}, {63'd0, rsp_valid}, 64'd0);
        chk64({tag, " rdata_clr"}, rsp_rdata, 64'd0);
        chk64({tag, " ready_back"}, {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        int acc;
        int rsps;
        vec_t v;

        vecs[0]  = '{1'b1, 2'b00, 1'b0, 64'h10,  64'h1122334455667788, 64'd0, 1'b0, 1};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 64'h10,  64'd0, 64'h1122334455667788, 1'b0, 2};
`ifdef DMEM_MISALIGN_TRAP_EN
        vecs[2]  = '{1'b0, 2'b01, 1'b1, 64'h12,  64'd0, 64'd0, 1'b1, 1};
`else
        vecs[2]  = '{1'b0, 2'b01, 1'b1, 64'h12,  64'd0, 64'h0000000055667788, 1'b0, 2};
`endif
        vecs[3]  = '{1'b1, 2'b11, 1'b0, 64'h13,  64'hFFFFFFFFFFFFFFAB, 64'd0, 1'b0, 2};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 64'h10,  64'd0, 64'h11223344AB667788, 1'b0, 2};
        vecs[5]  = '{1'b0, 2'b11, 1'b1, 64'h13,  64'd0, 64'hFFFFFFFFFFFFFFAB, 1'b0, 2};
        vecs[6]  = '{1'b0, 2'b11, 1'b0, 64'h13,  64'd0, 64'h00000000000000AB, 1'b0, 2};
        vecs[7]  = '{1'b0, 2'b10, 1'b1, 64'h12,  64'd0, 64'hFFFFFFFFFFFFAB66, 1'b0, 2};
        vecs[8]  = '{1'b0, 2'b00, 1'b0, 64'h800, 64'd0, 64'd0, 1'b1, 1};
        vecs[9]  = '{1'b1, 2'b00, 1'b0, 64'h0,   64'hA5A55A5A0F0FF0F0, 64'd0, 1'b0, 1};
        vecs[10] = '{1'b1, 2'b00, 1'b0, 64'h800, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1, 1};
        vecs[11] = '{1'b0, 2'b00, 1'b0, 64'h0,   64'd0, 64'hA5A55A5A0F0FF0F0, 1'b0, 2};
        vecs[12] = '{1'b1, 2'b01, 1'b0, 64'h1C,  64'h1234567880000001, 64'd0, 1'b0, 2};
        vecs[13] = '{1'b0, 2'b01, 1'b1, 64'h1C,  64'd0, 64'hFFFFFFFF80000001, 1'b0, 2};
        vecs[14] = '{1'b0, 2'b01, 1'b0, 64'h1C,  64'd0, 64'h0000000080000001, 1'b0, 2};
        vecs[15] = '{1'b0, 2'b10, 1'b0, 64'h1E,  64'd0, 64'h0000000000008000, 1'b0, 2};
        vecs[16] = '{1'b1, 2'b00, 1'b0, 64'h7F8, 64'hCAFEF00D12345678, 64'd0, 1'b0, 1};
        vecs[17] = '{1'b0, 2'b10, 1'b1, 64'h7FE, 64'd0, 64'hFFFFFFFFFFFFCAFE, 1'b0, 2};
        vecs[18] = '{1'b1, 2'b00, 1'b0, 64'h20,  64'h0123456789ABCDEF, 64'd0, 1'b0, 1};

        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 64'd0; req_wdata = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        chk64("rst ready", {63'd0, req_ready}, 64'd1);
        chk64("rst rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk64("rst rdata", rsp_rdata, 64'd0);
        chk64("rst err", {63'd0, rsp_err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Back-to-back loads with req_valid held high
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = 64'h10;
        req_valid = 1'b1;
        acc = 0;
        rsps = 0;
        for (int k = 0; k < 21; k++) begin
            if (req_ready) acc++;
            @(posedge clk); #1;
            if (rsp_valid) begin
                rsps++;
                chk64("b2b rdata", rsp_rdata, 64'h11223344AB667788);
                chk64("b2b ready_in_resp", {63'd0, req_ready}, 64'd0);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid) rsps++;
        end
        chkint("b2b accepts", acc, 7);
        chkint("b2b responses", rsps, 7);

        // Reset while a half store to 0x20 sits in MERGE
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 64'h20; req_wdata = 64'h000000000000BEEF;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk64("mrst ready_busy", {63'd0, req_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk64("mrst ready_async", {63'd0, req_ready}, 64'd1);
        repeat (2) begin
            @(posedge clk); #1;
            chk64("mrst no_rsp_in_rst", {63'd0, rsp_valid}, 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rsps = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (rsp_valid) rsps++;
        end
        chkint("mrst no_rsp_after", rsps, 0);
        chk64("mrst ready_after", {63'd0, req_ready}, 64'd1);
        v = '{1'b0, 2'b00, 1'b0, 64'h20, 64'd0, 64'h0123456789ABCDEF, 1'b0, 2};
        run_vec(v, "mrst reload");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
